// File: rtl/unaligned_bank_access_pkg.sv
// Shared memory types and default geometry for the banked byte memory.
package unaligned_bank_access_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LANES_DEF = 16;
  localparam int unsigned ROW_W_DEF = 16;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/unaligned_bank_access_adder.sv
// N-bit adder with carry in; used to step a bank row by one.
module Adder_with_carry_in_N
  import unaligned_bank_access_pkg::*;
#(
  parameter int unsigned N = ROW_W_DEF
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_c,
  output logic         cout_c
);

  localparam int unsigned SW = N + 1;

  assign {cout_c, sum_c} = SW'(a_i) + SW'(b_i) + SW'(cin_i);

endmodule

// File: rtl/unaligned_bank_access_rotator.sv
// Lane rotator. DIRECTION=0: out lane i = in lane (i-shift); DIRECTION=1: out lane i = in lane (i+shift).
module Byte_rotator_N
  import unaligned_bank_access_pkg::*;
#(
  parameter int unsigned LANES     = LANES_DEF,
  parameter int unsigned W         = BYTE_W,
  parameter bit          DIRECTION = 1'b0,
  parameter int unsigned OFF_W     = $clog2(LANES)
) (
  input  logic [LANES*W-1:0] in_i,
  input  logic [OFF_W-1:0]   shift_i,
  output logic [LANES*W-1:0] rot_c
);

  logic [OFF_W-1:0] src;

  // Select the source lane for every output lane (indices wrap modulo LANES).
  always_comb begin
    rot_c = '0;
    src   = '0;
    for (int i = 0; i < LANES; i++) begin
      src = DIRECTION ? (OFF_W'(i) + shift_i) : (OFF_W'(i) - shift_i);
      rot_c[i*W +: W] = in_i[src*W +: W];
    end
  end

endmodule

// File: rtl/unaligned_bank_access.sv
// Unaligned LANES-byte access over LANES byte-wide banks, with realigned read responses.
module unaligned_bank_access
  import unaligned_bank_access_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned ROW_W  = ROW_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [ROW_W+$clog2(LANES)-1:0]       req_addr,
  input  logic [LANES*8-1:0]                   req_wdata,
  input  logic [LANES-1:0]                     req_be,
  output logic [LANES-1:0]                     bank_en,
  output logic [LANES-1:0]                     bank_we,
  output logic [LANES*ROW_W-1:0]               bank_addr,
  output logic [LANES*8-1:0]                   bank_wdata,
  input  logic [LANES*8-1:0]                   bank_rdata,
  output logic                                 rsp_valid,
  output logic [LANES*8-1:0]                   rsp_rdata,
  output logic                                 rsp_wrap
);

  localparam int unsigned OFF_W  = $clog2(LANES);
  localparam int unsigned ADDR_W = ROW_W + OFF_W;
  localparam int unsigned BW     = $bits(byte_t);
  localparam int unsigned DW     = LANES * BW;

  logic [ROW_W-1:0]       row;
  logic [OFF_W-1:0]       off;
  logic                   accept;
  logic [DW-1:0]          wdata_rot_c;
  logic [DW-1:0]          rdata_rot_c;
  logic [LANES-1:0]       be_rot_c;
  logic [LANES-1:0]       carry_c;
  logic [LANES*ROW_W-1:0] lane_row_c;
  logic                   wrap_c;

  logic                              ready_q;
  logic [LANES-1:0]                  bank_en_q, bank_en_d;
  logic [LANES-1:0]                  bank_we_q, bank_we_d;
  logic [LANES*ROW_W-1:0]            bank_addr_q, bank_addr_d;
  logic [DW-1:0]                     bank_wdata_q, bank_wdata_d;
  logic [RD_LAT:0]                   tag_vld_q, tag_vld_d;
  logic [RD_LAT:0][OFF_W-1:0]        tag_off_q, tag_off_d;
  logic [RD_LAT:0]                   tag_wrap_q, tag_wrap_d;
  logic                              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]                     rsp_rdata_q, rsp_rdata_d;
  logic                              rsp_wrap_q, rsp_wrap_d;

  assign row    = req_addr[ADDR_W-1:OFF_W];
  assign off    = req_addr[OFF_W-1:0];
  assign accept = req_valid & ready_q;

  // Banks below the offset belong to the next row; a carry out means the row wrapped to 0.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    Adder_with_carry_in_N #(.N(ROW_W)) u_row_inc (
      .a_i    (row),
      .b_i    ('0),
      .cin_i  (OFF_W'(i) < off),
      .sum_c  (lane_row_c[i*ROW_W +: ROW_W]),
      .cout_c (carry_c[i])
    );
  end

  assign wrap_c = |carry_c;

  Byte_rotator_N #(.LANES(LANES), .W(BW), .DIRECTION(1'b0)) u_wdata_rot (
    .in_i    (req_wdata),
    .shift_i (off),
    .rot_c   (wdata_rot_c)
  );

  Byte_rotator_N #(.LANES(LANES), .W(1), .DIRECTION(1'b0)) u_be_rot (
    .in_i    (req_be),
    .shift_i (off),
    .rot_c   (be_rot_c)
  );

  // Read data is realigned with the offset travelling alongside it.
  Byte_rotator_N #(.LANES(LANES), .W(BW), .DIRECTION(1'b1)) u_rdata_rot (
    .in_i    (bank_rdata),
    .shift_i (tag_off_q[RD_LAT]),
    .rot_c   (rdata_rot_c)
  );

  // Next bank command: strobes only in the cycle after an accept; address/data hold otherwise.
  always_comb begin
    bank_en_d    = '0;
    bank_we_d    = '0;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    if (accept) begin
      bank_en_d    = req_we ? be_rot_c : '1;
      bank_we_d    = req_we ? be_rot_c : '0;
      bank_addr_d  = lane_row_c;
      bank_wdata_d = wdata_rot_c;
    end
  end

  // Read tag pipeline (stage 0 aligns with the bank access) and response capture.
  always_comb begin
    tag_vld_d   = {tag_vld_q[RD_LAT-1:0], accept & ~req_we};
    tag_off_d   = {tag_off_q[RD_LAT-1:0], off};
    tag_wrap_d  = {tag_wrap_q[RD_LAT-1:0], wrap_c};
    rsp_valid_d = tag_vld_q[RD_LAT];
    rsp_wrap_d  = tag_vld_q[RD_LAT] & tag_wrap_q[RD_LAT];
    rsp_rdata_d = rsp_rdata_q;
    if (tag_vld_q[RD_LAT]) begin
      rsp_rdata_d = rdata_rot_c;
    end
  end

  // State registers with synchronous reset; reset flushes every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b0;
      bank_en_q    <= '0;
      bank_we_q    <= '0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      tag_vld_q    <= '0;
      tag_off_q    <= '0;
      tag_wrap_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_wrap_q   <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      bank_en_q    <= bank_en_d;
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      tag_vld_q    <= tag_vld_d;
      tag_off_q    <= tag_off_d;
      tag_wrap_q   <= tag_wrap_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_wrap_q   <= rsp_wrap_d;
    end
  end

  assign req_ready  = ready_q;
  assign bank_en    = bank_en_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_wrap   = rsp_wrap_q;

endmodule
